// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: time-multiplexed fixed-point neuron, one multiplier, loadable weights/bias, valid/ready in and out
module neuron_mac_seq #(
    parameter int N_IN   = 5,
    parameter int DATA_W = 16,
    parameter int WGT_W  = 16,
    parameter int ACC_W  = 40,
    parameter int SHIFT  = 13,
    parameter int OUT_W  = 16,
    parameter int ACT    = 1,
    parameter int ROUND  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN*DATA_W-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    input  logic                       w_wr_en,
    input  logic [$clog2(N_IN+1)-1:0]  w_addr,
    input  logic [WGT_W-1:0]           w_data,
    output logic                       w_err
);
    localparam int AW = $clog2(N_IN + 1);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW = DATA_W + WGT_W;
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] RND  = (ROUND != 0 && SHIFT > 0) ? SW'(1) << (SHIFT - 1) : '0;
    localparam logic signed [SW-1:0] OMAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] OMIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, ACT_S, OUT} state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  x_q [N_IN];
    logic signed [DATA_W-1:0]  x_d [N_IN];
    logic signed [WGT_W-1:0]   w_q [N_IN];
    logic signed [WGT_W-1:0]   w_d [N_IN];
    logic signed [WGT_W-1:0]   bias_q, bias_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [OUT_W-1:0]          out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      w_err_q, w_err_d;
    logic                      w_ok;
    logic signed [PW-1:0]      prod;
    logic signed [SW-1:0]      s, r, rl;
    logic [OUT_W-1:0]          sat;

    assign in_ready  = (state_q == IDLE) && reset;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign w_err     = w_err_q;

    always_comb begin
        w_ok = w_wr_en && state_q == IDLE && w_addr <= AW'(N_IN);
        prod = x_q[idx_q] * w_q[idx_q];
        // bias sits in product scale, so it joins the sum before the shift
        s    = SW'(acc_q) + SW'(bias_q) + RND;
        r    = s >>> SHIFT;
        rl   = (ACT != 0 && r[SW-1]) ? '0 : r;
        sat  = rl > OMAX ? OMAX[OUT_W-1:0] : rl < OMIN ? OMIN[OUT_W-1:0] : rl[OUT_W-1:0];
        state_d     = state_q;
        x_d         = x_q;
        w_d         = w_q;
        bias_d      = bias_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        w_err_d     = w_wr_en && !w_ok;
        for (int i = 0; i < N_IN; i++)
            if (w_ok && w_addr == AW'(i)) w_d[i] = w_data;
        if (w_ok && w_addr == AW'(N_IN)) bias_d = w_data;
        case (state_q)
            IDLE: if (in_valid) begin
                for (int i = 0; i < N_IN; i++) x_d[i] = in_data[i*DATA_W +: DATA_W];
                acc_d   = '0;
                idx_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d   = acc_q + ACC_W'(prod);
                idx_d   = idx_q + IW'(1);
                state_d = (idx_q == IW'(N_IN - 1)) ? ACT_S : MAC;
            end
            ACT_S: begin
                out_data_d  = sat;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            default: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '{default: '0};
            w_q         <= '{default: '0};
            bias_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            w_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            w_q         <= w_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            w_err_q     <= w_err_d;
        end
    end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: two neuron instances (ReLU/floor and identity/round-half-up) driven in lockstep against a reference model
module tb_neuron_mac_seq;
    typedef logic [4:0][15:0] vec5_t;
    typedef struct packed {
        vec5_t       x;
        vec5_t       w;
        logic [15:0] b;
        int          e0;
        int          e1;
    } rec_t;

    logic        clk = 0, reset = 0, in_valid = 0, out_ready = 0, w_wr_en = 0;
    logic [79:0] in_data = '0;
    logic [2:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic        ir0, ir1, ov0, ov1, we0, we1;
    logic [15:0] od0, od1;
    int          checks = 0, failures = 0;
    rec_t        tbl [8];

    always #5 clk = ~clk;

    neuron_mac_seq d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_err(we0)
    );

    neuron_mac_seq #(.ACT(0), .ROUND(1)) d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_err(we1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input longint a, input longint e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
        end
    endtask

    function automatic vec5_t v5(input int a, input int b, input int c, input int d, input int e);
        vec5_t r;
        r[0] = 16'(a);
        r[1] = 16'(b);
        r[2] = 16'(c);
        r[3] = 16'(d);
        r[4] = 16'(e);
        return r;
    endfunction

    // plain-integer reference: dot product, bias, optional half-up rounding, floor shift, relu, clamp
    function automatic int model(input vec5_t x, input vec5_t w, input logic [15:0] b, input bit relu, input bit rnd);
        longint s = 0;
        for (int i = 0; i < 5; i++) s += longint'($signed(x[i])) * longint'($signed(w[i]));
        s += longint'($signed(b));
        if (rnd) s += 4096;
        s = s >>> 13;
        if (relu && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic wr(input int a, input int d, input bit err);
        w_wr_en = 1;
        w_addr  = 3'(a);
        w_data  = 16'(d);
        tick();
        w_wr_en = 0;
        chk($sformatf("w_err_addr%0d", a), {we0, we1}, {err, err});
    endtask

    task automatic load(input vec5_t w, input logic [15:0] b);
        for (int i = 0; i < 5; i++) wr(i, int'(w[i]), 0);
        wr(5, int'(b), 0);
    endtask

    task automatic start(input vec5_t x);
        int n = 0;
        in_data  = x;
        in_valid = 1;
        while (!ir0 && n < 50) begin
            tick();
            n++;
        end
        if (!ir0) chk("accept_timeout", ir0, 1);
        tick();
        in_valid = 0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!ov0 && lat < 50) begin
            tick();
            lat++;
        end
        chk("out_valid_d0", ov0, 1);
        chk("out_valid_d1", ov1, 1);
    endtask

    task automatic retire(input int hold);
        out_ready = 0;
        repeat (hold) tick();
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("retire_valid", {ov0, ov1}, 0);
    endtask

    task automatic run(input string n, input vec5_t x, input int e0, input int e1, input int hold);
        int lat;
        start(x);
        wait_out(lat);
        chk({n, "_lat"}, lat, 6);
        chk({n, "_d0"}, $signed(od0), e0);
        chk({n, "_d1"}, $signed(od1), e1);
        retire(hold);
        chk({n, "_retained"}, $signed(od0), e0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int    lat, bad;
        vec5_t x, w, ramp, w8k;
        logic [15:0] b;
        ramp = v5(1000, 2000, 3000, 4000, 5000);
        w8k  = v5(8192, 8192, 8192, 8192, 8192);
        tbl[0] = '{x: ramp, w: w8k, b: 16'd0, e0: 15000, e1: 15000};
        tbl[1] = '{x: v5(-1000, -1000, -1000, -1000, -1000), w: w8k, b: 16'd0, e0: 0, e1: -5000};
        tbl[2] = '{x: v5(32767, 32767, 32767, 32767, 32767), w: v5(32767, 32767, 32767, 32767, 32767), b: 16'd0, e0: 32767, e1: 32767};
        tbl[3] = '{x: v5(32767, 32767, 32767, 32767, 32767), w: v5(-32768, -32768, -32768, -32768, -32768), b: 16'd0, e0: 0, e1: -32768};
        tbl[4] = '{x: v5(1, 0, 0, 0, 0), w: v5(4096, 0, 0, 0, 0), b: 16'd0, e0: 0, e1: 1};
        tbl[5] = '{x: v5(1, 0, 0, 0, 0), w: v5(4096, 0, 0, 0, 0), b: 16'd8192, e0: 1, e1: 2};
        tbl[6] = '{x: v5(-3, 0, 0, 0, 0), w: v5(4096, 0, 0, 0, 0), b: 16'd0, e0: 0, e1: -1};
        tbl[7] = '{x: v5(0, 0, 0, 0, 7), w: v5(0, 0, 0, 0, -8192), b: 16'hE000, e0: 0, e1: -8};

        reset = 0;
        tick();
        tick();
        chk("rst_in_ready", {ir0, ir1}, 0);
        chk("rst_out_valid", {ov0, ov1}, 0);
        chk("rst_out_data", {od0, od1}, 0);
        chk("rst_w_err", {we0, we1}, 0);
        reset = 1;
        #1;
        chk("rst_release_in_ready", {ir0, ir1}, 3);

        for (int i = 0; i < 8; i++) begin
            load(tbl[i].w, tbl[i].b);
            run($sformatf("tbl%0d", i), tbl[i].x, tbl[i].e0, tbl[i].e1, i % 3);
        end

        // backpressure with a second vector waiting
        load(w8k, 16'd0);
        start(ramp);
        wait_out(lat);
        chk("bp_lat", lat, 6);
        in_data   = v5(100, 200, 300, 400, 500);
        in_valid  = 1;
        out_ready = 0;
        bad = 0;
        repeat (10) begin
            tick();
            if (!ov0 || !ov1 || $signed(od0) != 15000 || $signed(od1) != 15000 || ir0 || ir1) bad++;
        end
        chk("bp_stable_cycles_bad", bad, 0);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("bp_retire_valid", {ov0, ov1}, 0);
        chk("bp_ready_after_retire", {ir0, ir1}, 3);
        tick();
        chk("bp_second_accepted", {ir0, ir1}, 0);
        in_valid = 0;
        wait_out(lat);
        chk("bp2_lat", lat, 6);
        chk("bp2_d0", $signed(od0), 1500);
        chk("bp2_d1", $signed(od1), 1500);
        retire(0);

        // bias write in the same cycle as the accept is used by that vector
        in_data  = ramp;
        in_valid = 1;
        w_wr_en  = 1;
        w_addr   = 3'd5;
        w_data   = 16'd8192;
        chk("wa_in_ready", {ir0, ir1}, 3);
        tick();
        in_valid = 0;
        w_wr_en  = 0;
        chk("wa_w_err", {we0, we1}, 0);
        wait_out(lat);
        chk("wa_lat", lat, 6);
        chk("wa_d0", $signed(od0), 15001);
        chk("wa_d1", $signed(od1), 15001);
        retire(1);

        // rejected writes: during MAC and out of range in IDLE
        start(ramp);
        wr(0, 1, 1);
        tick();
        chk("mac_err_pulse_end", {we0, we1}, 0);
        wait_out(lat);
        chk("prot_lat", lat, 4);
        chk("prot_d0", $signed(od0), 15001);
        chk("prot_d1", $signed(od1), 15001);
        retire(0);
        wr(6, 123, 1);
        tick();
        chk("addr_err_pulse_end", {we0, we1}, 0);
        run("prot_after", ramp, 15001, 15001, 0);

        // reset in the middle of MAC clears coefficients and drops the result
        start(ramp);
        tick();
        reset = 0;
        tick();
        chk("mr_in_ready", {ir0, ir1}, 0);
        chk("mr_out_valid", {ov0, ov1}, 0);
        reset = 1;
        #1;
        chk("mr_release_in_ready", {ir0, ir1}, 3);
        bad = 0;
        repeat (10) begin
            tick();
            if (ov0 || ov1) bad++;
        end
        chk("mr_spurious_valid", bad, 0);
        run("mr_cleared", ramp, 0, 0, 0);

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 5; i++) begin
                w[i] = (it % 2) ? 16'(int'($urandom_range(0, 400)) - 200) : 16'($urandom);
                x[i] = (it % 3 == 0) ? 16'(int'($urandom_range(0, 2000)) - 1000) : 16'($urandom);
            end
            b = 16'($urandom);
            load(w, b);
            run($sformatf("rnd%0d", it), x, model(x, w, b, 1, 0), model(x, w, b, 0, 1), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/neuron_mac_seq.md
Name: neuron_mac_seq

Overview:
- Parametrised, time-multiplexed fixed-point neuron for the layer generator.
- Computes out = sat(act(round((sum over i of x[i]*w[i] + bias) >>> SHIFT))) over N_IN inputs, using one signed multiplier and sequential accumulation.
- Weights and bias are run-time loadable through a write port.
- Vectors enter and results leave over valid/ready handshakes, so nodes can be chained with backpressure.

Parameters:
- N_IN, 5: number of inputs per neuron (>=1).
- DATA_W, 16: signed input sample width.
- WGT_W, 16: signed weight and bias width.
- ACC_W, 40: signed accumulator width. Must be >= DATA_W+WGT_W+clog2(N_IN)+1.
- SHIFT, 13: arithmetic right shift applied to (acc+bias) before activation.
- OUT_W, 16: signed output width.
- ACT, 1: activation. 0 = identity; 1 = ReLU.
- ROUND, 0: rounding before shift. 0 = truncate (floor); 1 = add 1<<(SHIFT-1) before the shift (round half up).

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a vector.
- in_data, input, N_IN*DATA_W: packed samples. x[i] = in_data[i*DATA_W +: DATA_W].
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts out_data.
- out_data, output, OUT_W: signed result.
- w_wr_en, input, 1: coefficient write strobe.
- w_addr, input, clog2(N_IN+1): write address. 0..N_IN-1 selects a weight; N_IN selects the bias.
- w_data, input, WGT_W: signed coefficient.
- w_err, output, 1: one-cycle pulse when a write is rejected.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state <= IDLE; acc, idx, out_data, all weights and bias <= 0.
  - out_valid <= 0; w_err <= 0.
  - in_ready is 0 while reset is low.
- in_ready = (state==IDLE) && reset. It is combinational from registered state.

FSM:
- IDLE:
  - On in_valid && in_ready, latch all N_IN samples into an internal vector register.
  - acc <= 0, idx <= 0, go to MAC.
  - Later changes on in_data have no effect on the result.
- MAC:
  - Each cycle: acc <= acc + sext(x[idx]*w[idx]). The product is full precision, DATA_W+WGT_W bits, signed.
  - idx increments each cycle. When idx==N_IN-1, go to ACT. MAC lasts exactly N_IN cycles.
- ACT (one cycle):
  - s = acc + sext(bias). Bias is in product scale, i.e. unshifted.
  - If ROUND=1, s += 1<<(SHIFT-1).
  - r = s >>> SHIFT.
  - If ACT=1 and r<0, r = 0.
  - Saturate r to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_data <= r, out_valid <= 1, go to OUT.
- OUT:
  - Hold out_data and out_valid stable while out_ready==0.
  - On out_ready==1: out_valid <= 0, go to IDLE. in_ready rises the next cycle.
  - There is no accept in the same cycle as output retire.

Timing and result retention:
- Latency: vector accepted at edge k; out_valid is high after edge k+N_IN+1.
- Throughput: one vector per N_IN+3 cycles when out_ready is held at 1.
- out_data keeps its last value after retirement until the next ACT.

Coefficient writes:
- Accepted only in IDLE with w_addr <= N_IN. Takes effect from the next edge.
- Writes in MAC, ACT or OUT, or with w_addr > N_IN, are dropped. w_err pulses high for one cycle.
- A write in the same IDLE cycle as a vector accept is applied and is used by that vector.

Other rules:
- Reset mid-operation: abandon the computation, return to IDLE, clear coefficients. No out_valid pulse is produced.
- The accumulator never wraps provided ACC_W meets the rule above. Saturation is applied only at the output.

Test Plan:
Defaults throughout unless stated.

1. Identity computation:
   - Stimulus: weights 0..4 = 8192, bias 0, x = 1000, 2000, 3000, 4000, 5000.
   - Response: out_data = 15000. out_valid rises exactly 6 edges after accept.
2. ReLU clamp and identity mode:
   - Stimulus: same weights, x = -1000 ×5.
   - Response: with ACT=1, out_data = 0. With ACT=0, out_data = -5000.
3. Saturation:
   - Stimulus: weights 32767, x = 32767 ×5.
   - Response: out_data = 32767.
   - Stimulus with ACT=0: weights -32768.
   - Response: out_data = -32768.
4. Rounding:
   - Stimulus: w0 = 4096, x0 = 1, others 0.
   - Response: ROUND=0 gives 0; ROUND=1 gives 1.
   - Stimulus: add bias 8192 (address 5).
   - Response: ROUND=0 gives 1.
5. Backpressure:
   - Stimulus: hold out_ready = 0 for 10 cycles with in_valid = 1 and a second vector presented.
   - Response: out_data and out_valid are stable; in_ready = 0; the second vector is accepted only in the cycle after out_ready rises.
6. Protection:
   - Stimulus: issue w_wr_en during MAC; also w_addr = 6 in IDLE.
   - Response: w_err pulses once each, and the coefficients are unchanged.
   - Stimulus: drive reset low at MAC cycle 2.
   - Response: no out_valid; in_ready = 1 one cycle after reset releases; weights read back as 0, so the next result is 0.
